hc_fifo_wr_drain: RTL and testbench

- Consumer at the read side of an hc_fifo line buffer.
- Pops 512-bit lines from the FIFO dequeue interface and issues line-granular memory write requests to the host-memory write channel.
- Write addresses increment from a programmed base.
- Counts write responses, enforces an outstanding-request limit, and signals completion once every issued line is acknowledged.

---
 rtl/hc_fifo_wr_drain.sv | 137 +++++++++++++
 tb/tb_hc_fifo_wr_drain.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hc_fifo_wr_drain.sv
// hc_fifo_wr_drain: drains 512-bit lines from an hc_fifo into line-granular host-memory write requests.
// Latency: a write request is presented (registered) the cycle after its FIFO dequeue; one request per cycle max.
// Backpressure: wr_almost_full, an empty FIFO or a full outstanding window stop new dequeues; a registered request is always presented.
module hc_fifo_wr_drain #(
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 42,
  parameter int LEN_WIDTH       = 32,
  parameter int MAX_OUTSTANDING = 64,
  localparam int OUT_WIDTH      = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  num_lines,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_not_empty,
  output logic                  fifo_deq,
  input  logic                  wr_almost_full,
  output logic                  wr_req_valid,
  output logic [ADDR_WIDTH-1:0] wr_req_addr,
  output logic [DATA_WIDTH-1:0] wr_req_data,
  input  logic                  wr_rsp_valid,
  output logic                  busy,
  output logic                  done,
  output logic [OUT_WIDTH-1:0]  outstanding
);

  typedef enum logic [1:0] {IDLE, RUN, WAIT_RSP, DONE} state_t;

  localparam logic [OUT_WIDTH-1:0] OUT_MAX = OUT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [OUT_WIDTH-1:0] OUT_ONE = OUT_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issued;
  logic [LEN_WIDTH-1:0]  acked;
  logic [LEN_WIDTH-1:0]  acked_nxt;
  logic                  issue;
  logic                  rsp_hit;
  logic                  last_issue;
  logic                  start_ok;

  // Issue qualification; a response only counts while something is outstanding.
  always_comb begin
    start_ok   = (state == IDLE) && start;
    issue      = (state == RUN) && fifo_not_empty && !wr_almost_full &&
                 (issued < len_q) && (outstanding < OUT_MAX);
    rsp_hit    = wr_rsp_valid && (outstanding != '0);
    last_issue = issue && ((issued + LEN_ONE) == len_q);
    acked_nxt  = rsp_hit ? (acked + LEN_ONE) : acked;
  end

  assign fifo_deq = issue;

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (num_lines == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_issue) state_nxt = WAIT_RSP;
      end
      WAIT_RSP: begin
        busy = 1'b1;
        // Counts the response arriving this cycle, so completion is not delayed a cycle.
        if (acked_nxt == len_q) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Transfer bookkeeping: programmed base/length, issue and acknowledge counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q <= '0;
      len_q  <= '0;
      issued <= '0;
      acked  <= '0;
    end else if (start_ok) begin
      base_q <= base_addr;
      len_q  <= num_lines;
      issued <= '0;
      acked  <= '0;
    end else begin
      if (issue) issued <= issued + LEN_ONE;
      acked <= acked_nxt;
    end
  end

  // Outstanding window: an issue and a counted response in one cycle cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({issue, rsp_hit})
        2'b10:   outstanding <= outstanding + OUT_ONE;
        2'b01:   outstanding <= outstanding - OUT_ONE;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Registered write request; address wraps silently at the top of the address space.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_req_valid <= 1'b0;
      wr_req_addr  <= '0;
      wr_req_data  <= '0;
    end else begin
      wr_req_valid <= issue;
      if (issue) begin
        wr_req_addr <= base_q + ADDR_WIDTH'(issued);
        wr_req_data <= fifo_data;
      end
    end
  end

endmodule

// File: tb/tb_hc_fifo_wr_drain.sv
// tb_hc_fifo_wr_drain: randomized scoreboard bench for hc_fifo_wr_drain.
// Expected requests (base+i, i-th line) are queued at start; a monitor pops them as requests appear.
// The bench owns the FIFO and the write-response channel; outstanding is tracked as issues minus counted responses.
module tb_hc_fifo_wr_drain;

  localparam int DW   = 512;
  localparam int AW   = 42;
  localparam int LW   = 32;
  localparam int MAXO = 4;
  localparam int OW   = $clog2(MAXO + 1);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] num_lines;
  logic [DW-1:0] fifo_data;
  logic          fifo_not_empty;
  logic          fifo_deq;
  logic          wr_almost_full;
  logic          wr_req_valid;
  logic [AW-1:0] wr_req_addr;
  logic [DW-1:0] wr_req_data;
  logic          wr_rsp_valid;
  logic          busy;
  logic          done;
  logic [OW-1:0] outstanding;

  hc_fifo_wr_drain #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_lines(num_lines),
    .fifo_data(fifo_data), .fifo_not_empty(fifo_not_empty), .fifo_deq(fifo_deq),
    .wr_almost_full(wr_almost_full), .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr),
    .wr_req_data(wr_req_data), .wr_rsp_valid(wr_rsp_valid), .busy(busy), .done(done),
    .outstanding(outstanding)
  );

  initial forever #5 clk = ~clk;

  req_t          expq[$];
  logic [DW-1:0] fifoq[$];
  logic [DW-1:0] pendq[$];
  int            rsp_due[$];
  int vectors = 0, miscompares = 0;
  int cyc = 0, mo = 0, acked_m = 0, peak = 0, cur_n = 0;
  int deq_cnt = 0, req_cnt = 0, done_cnt = 0, first_deq = -1, last_deq = -1;
  int release_n = 0, held = 0, rsp_delay = 1;
  bit auto_rsp = 1'b1, deq_s = 1'b0, rsp_s = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] l;
    for (int k = 0; k < DW / 32; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic fifo_refresh();
    fifo_not_empty = (fifoq.size() > 0);
    if (fifoq.size() > 0) fifo_data = fifoq[0];
    else                  fifo_data = '0;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic feed(input int k);
    repeat (k) if (pendq.size() > 0) fifoq.push_back(pendq.pop_front());
    fifo_refresh();
  endtask

  // Queue the expected requests for a transfer, preload part of its lines, pulse start.
  task automatic start_xfer(input logic [AW-1:0] base, input int n, input int preload);
    logic [DW-1:0] line;
    req_t r;
    deq_cnt = 0; req_cnt = 0; done_cnt = 0; peak = 0; acked_m = 0;
    first_deq = -1; last_deq = -1; cur_n = n;
    for (int i = 0; i < n; i++) begin
      line   = rand_line();
      r.addr = base + AW'(i);
      r.data = line;
      expq.push_back(r);
      pendq.push_back(line);
    end
    feed(preload);
    base_addr = base;
    num_lines = LW'(n);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      tick();
      k++;
    end
    chk({name, "_done_seen"}, done_cnt > 0, 1);
    tick(3);
    chk({name, "_done_once"}, done_cnt, 1);
    chk({name, "_deq_count"}, deq_cnt, cur_n);
    chk({name, "_req_count"}, req_cnt, cur_n);
    chk({name, "_sb_empty"}, expq.size(), 0);
    chk({name, "_idle_busy"}, busy, 0);
  endtask

  // Pre-edge sampler: records what the DUT will act on at the coming edge and checks issue rules.
  initial forever begin
    @(negedge clk);
    #4;
    deq_s = fifo_deq;
    rsp_s = wr_rsp_valid;
    if (!reset && fifo_deq) begin
      chk("deq_not_under_af", wr_almost_full, 0);
      chk("deq_fifo_nonempty", fifo_not_empty, 1);
      chk("deq_window_open", mo < MAXO, 1);
      chk("deq_within_len", deq_cnt < cur_n, 1);
      chk("deq_while_busy", busy, 1);
    end
  end

  // Environment: FIFO model, response generator and scoreboard monitor, once per cycle.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (reset) begin
      mo = 0; acked_m = 0; release_n = 0; held = 0;
      rsp_due.delete();
      wr_rsp_valid = 1'b0;
      deq_s = 1'b0; rsp_s = 1'b0;
      fifo_refresh();
    end else begin
      if (rsp_s && mo > 0) begin
        mo--;
        acked_m++;
      end
      if (deq_s) begin
        mo++;
        deq_cnt++;
        if (first_deq < 0) first_deq = cyc;
        last_deq = cyc;
        if (fifoq.size() > 0) void'(fifoq.pop_front());
      end
      if (mo > peak) peak = mo;
      chk("outstanding", outstanding, mo);
      if (wr_req_valid) begin
        req_t e;
        req_cnt++;
        if (expq.size() == 0) begin
          chk("unexpected_req", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("req_addr", wr_req_addr, e.addr);
          chk("req_data", wr_req_data, e.data);
        end
        if (auto_rsp) rsp_due.push_back(cyc + rsp_delay);
        else          held++;
      end
      if (done) begin
        done_cnt++;
        chk("done_after_all_acked", acked_m, cur_n);
        chk("done_busy_low", busy, 0);
      end
      wr_rsp_valid = 1'b0;
      if (rsp_due.size() > 0 && rsp_due[0] <= cyc) begin
        void'(rsp_due.pop_front());
        wr_rsp_valid = 1'b1;
      end else if (release_n > 0) begin
        release_n--;
        wr_rsp_valid = 1'b1;
      end
      fifo_refresh();
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; num_lines = '0;
    wr_almost_full = 1'b0; wr_rsp_valid = 1'b0;
    fifo_refresh();
    tick(2);
    chk("rst_fifo_deq", fifo_deq, 0);
    chk("rst_req_valid", wr_req_valid, 0);
    chk("rst_req_addr", wr_req_addr, 0);
    chk("rst_req_data", wr_req_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_outstanding", outstanding, 0);
    reset = 1'b0;
    tick(2);

    // Spurious responses while idle: ignored, no completion.
    release_n = 2;
    tick(4);
    chk("spurious_outstanding", outstanding, 0);
    chk("spurious_no_done", done_cnt, 0);

    // Basic transfer, responses shortly after each request.
    auto_rsp = 1'b1;
    start_xfer(42'h100, 4, 4);
    wait_done("basic", 100);
    chk("basic_deq_consecutive", last_deq - first_deq, 3);
    chk("basic_peak", (peak == 2) || (peak == 3), 1);

    // Backpressure for cycles 2-5 of a 6-line transfer.
    start_xfer(AW'($urandom), 6, 6);
    tick();
    wr_almost_full = 1'b1;
    tick(4);
    wr_almost_full = 1'b0;
    #2;
    chk("bp_resume_deq", fifo_deq, 1);
    wait_done("backpressure", 100);

    // Outstanding limit with responses withheld, then released one at a time.
    auto_rsp = 1'b0;
    start_xfer(AW'($urandom), 7, 7);
    tick(15);
    chk("lim_outstanding_full", outstanding, MAXO);
    chk("lim_req_count", req_cnt, MAXO);
    for (int r = 1; r <= 2; r++) begin
      release_n = 1;
      held--;
      tick(6);
      chk("lim_one_more_req", req_cnt, MAXO + r);
      chk("lim_window_refilled", outstanding, MAXO);
    end
    auto_rsp = 1'b1;
    release_n = held;
    held = 0;
    wait_done("limit", 200);

    // Zero-length transfer.
    start_xfer(AW'($urandom), 0, 0);
    chk("zero_done_pulse", done, 1);
    chk("zero_busy", busy, 0);
    tick();
    chk("zero_done_clear", done, 0);
    chk("zero_no_deq", deq_cnt, 0);
    chk("zero_no_req", req_cnt, 0);
    chk("zero_done_once", done_cnt, 1);

    // Empty-FIFO stall plus a start pulse that must be ignored while busy.
    start_xfer(AW'($urandom), 5, 2);
    tick(8);
    chk("stall_busy", busy, 1);
    chk("stall_req_count", req_cnt, 2);
    base_addr = AW'($urandom);
    num_lines = 32'd9;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    feed(3);
    wait_done("busy_start", 200);

    // Address wrap at the top of the address space.
    start_xfer({AW{1'b1}}, 2, 2);
    wait_done("wrap", 100);

    // Randomized transfers with random FIFO refill and response delay.
    for (int t = 0; t < 4; t++) begin
      int n;
      n = $urandom_range(12, 1);
      rsp_delay = $urandom_range(4, 0);
      start_xfer(AW'($urandom), n, $urandom_range(n, 0));
      for (int c = 0; c < 40; c++) begin
        if ($urandom_range(2, 0) == 0) feed(1);
        wr_almost_full = ($urandom_range(3, 0) == 0);
        tick();
      end
      wr_almost_full = 1'b0;
      feed(n);
      wait_done("random", 300);
    end
    rsp_delay = 1;

    // Reset in the middle of an 8-line transfer, then a fresh short transfer.
    start_xfer(AW'($urandom), 8, 8);
    for (int k = 0; k < 50 && deq_cnt < 3; k++) tick();
    chk("midrst_reached_three", deq_cnt >= 3, 1);
    reset = 1'b1;
    #1;
    chk("midrst_fifo_deq", fifo_deq, 0);
    chk("midrst_req_valid", wr_req_valid, 0);
    chk("midrst_req_addr", wr_req_addr, 0);
    chk("midrst_req_data", wr_req_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_outstanding", outstanding, 0);
    expq.delete();
    fifoq.delete();
    pendq.delete();
    fifo_refresh();
    tick(2);
    reset = 1'b0;
    tick();
    start_xfer(AW'($urandom), 2, 0);
    tick(5);
    chk("post_rst_stall_busy", busy, 1);
    feed(2);
    wait_done("post_reset", 100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
